// File: rtl/urv_dm_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and the
// bus transaction record that is forwarded or latched at grant.
package urv_dm_arbiter_pkg;

  localparam int unsigned ARB_WAIT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_C = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        store;
  } mem_txn_t;

  // A request with both load and store high is a store.
  function automatic mem_txn_t make_txn(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] sel, input logic store);
    mem_txn_t t;
    t.addr  = addr;
    t.data  = data;
    t.sel   = sel;
    t.store = store;
    return t;
  endfunction

endpackage

// File: rtl/urv_dm_arbiter.sv
// Core/debug arbiter for the single data-memory port with debug starvation guard.
// Optional bus timeout abort is built when URV_DM_ARB_TIMEOUT_EN is defined.
module urv_dm_arbiter
  import urv_dm_arbiter_pkg::*;
#(
  parameter int unsigned G_MAX_WAIT = 8,
  parameter int unsigned G_TIMEOUT  = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_data_s_i,
  input  logic [3:0]  c_select_i,
  input  logic        c_load_i,
  input  logic        c_store_i,
  output logic        c_ready_o,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_data_s_i,
  input  logic [3:0]  d_select_i,
  input  logic        d_load_i,
  input  logic        d_store_i,
  output logic        d_ready_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        c_err_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_s_o,
  output logic [3:0]  m_select_o,
  output logic        m_load_o,
  output logic        m_store_o,
  input  logic [31:0] m_data_l_i,
  input  logic        m_ready_i
);

  localparam logic [ARB_WAIT_W-1:0] MAX_WAIT = ARB_WAIT_W'(G_MAX_WAIT);

  arb_state_e            state_q, state_d;
  logic [ARB_WAIT_W-1:0] wait_q, wait_d;
  mem_txn_t              lat_q, lat_d;
  logic [31:0]           d_rdata_q, d_rdata_d;
  logic                  d_ready_q, d_ready_d;
  logic                  d_err_q, d_err_d;

  logic     c_req_s, d_req_s, c_win_s, d_win_s;
  logic     bus_vld_s, c_ready_s, c_err_s, abort_s;
  mem_txn_t c_txn_s, d_txn_s, bus_txn_s;

`ifdef URV_DM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(G_TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;

  // Count stalled BUSY cycles; abort on the cycle the count reaches G_TIMEOUT.
  always_comb begin
    abort_s = (state_q != ARB_IDLE) && !m_ready_i && (tmo_q == TMO_LAST);
    if (state_q == ARB_IDLE) begin
      tmo_d = 8'd0;
    end else if (!m_ready_i) begin
      tmo_d = tmo_q + 8'd1;
    end else begin
      tmo_d = 8'd0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  // Arbitration, transaction latch and next-state logic.
  always_comb begin
    c_req_s   = c_load_i | c_store_i;
    d_req_s   = d_load_i | d_store_i;
    c_txn_s   = make_txn(c_addr_i, c_data_s_i, c_select_i, c_store_i);
    d_txn_s   = make_txn(d_addr_i, d_data_s_i, d_select_i, d_store_i);
    state_d   = state_q;
    wait_d    = wait_q;
    lat_d     = lat_q;
    d_rdata_d = d_rdata_q;
    d_ready_d = 1'b0;
    d_err_d   = 1'b0;
    c_ready_s = 1'b0;
    c_err_s   = 1'b0;
    c_win_s   = 1'b0;
    d_win_s   = 1'b0;
    bus_vld_s = 1'b0;
    bus_txn_s = '0;
    case (state_q)
      ARB_IDLE: begin
        d_win_s   = d_req_s & ((wait_q == MAX_WAIT) | ~c_req_s);
        c_win_s   = c_req_s & ~d_win_s;
        bus_vld_s = c_win_s | d_win_s;
        if (d_win_s) begin
          bus_txn_s = d_txn_s;
        end else if (c_win_s) begin
          bus_txn_s = c_txn_s;
        end else begin
          bus_txn_s = '0;
        end
        if (bus_vld_s && m_ready_i) begin
          c_ready_s = c_win_s;
          d_ready_d = d_win_s;
          if (d_win_s && !d_txn_s.store) begin
            d_rdata_d = m_data_l_i;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else if (bus_vld_s) begin
          lat_d   = bus_txn_s;
          state_d = d_win_s ? ARB_BUSY_D : ARB_BUSY_C;
        end else begin
          state_d = ARB_IDLE;
        end
        if (!d_req_s || d_win_s) begin
          wait_d = '0;
        end else if (wait_q < MAX_WAIT) begin
          wait_d = wait_q + 8'd1;
        end else begin
          wait_d = wait_q;
        end
      end
      ARB_BUSY_C, ARB_BUSY_D: begin
        // Requester withdrawal is ignored here; the latched copy owns the bus.
        bus_vld_s = 1'b1;
        bus_txn_s = lat_q;
        if (m_ready_i || abort_s) begin
          state_d = ARB_IDLE;
          if (state_q == ARB_BUSY_C) begin
            c_ready_s = 1'b1;
            c_err_s   = abort_s;
          end else begin
            d_ready_d = 1'b1;
            d_err_d   = abort_s;
            if (m_ready_i && !lat_q.store) begin
              d_rdata_d = m_data_l_i;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end
        end else begin
          state_d = state_q;
        end
        if (!d_req_s) begin
          wait_d = '0;
        end else if ((state_q == ARB_BUSY_C) && (wait_q < MAX_WAIT)) begin
          wait_d = wait_q + 8'd1;
        end else begin
          wait_d = wait_q;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, wait counter, latch and debug response registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ARB_IDLE;
      wait_q    <= '0;
      lat_q     <= '0;
      d_rdata_q <= 32'd0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      lat_q     <= lat_d;
      d_rdata_q <= d_rdata_d;
      d_ready_q <= d_ready_d;
      d_err_q   <= d_err_d;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign m_addr_o   = rst_n_i ? bus_txn_s.addr : 32'd0;
  assign m_data_s_o = rst_n_i ? bus_txn_s.data : 32'd0;
  assign m_select_o = rst_n_i ? bus_txn_s.sel  : 4'd0;
  assign m_load_o   = rst_n_i & bus_vld_s & ~bus_txn_s.store;
  assign m_store_o  = rst_n_i & bus_vld_s & bus_txn_s.store;
  assign c_ready_o  = rst_n_i & c_ready_s;
  assign c_err_o    = rst_n_i & c_err_s;
  assign d_ready_o  = d_ready_q;
  assign d_err_o    = d_err_q;
  assign d_rdata_o  = d_rdata_q;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Randomized scoreboard bench for urv_dm_arbiter with a transaction-level reference model.
module tb_urv_dm_arbiter;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] c_addr = '0, c_data = '0, d_addr = '0, d_data = '0, m_data_l = '0;
  logic [3:0]  c_sel = '0, d_sel = '0;
  logic        c_load = 1'b0, c_store = 1'b0, d_load = 1'b0, d_store = 1'b0, m_ready = 1'b0;
  logic        c_ready, d_ready, d_err, c_err, m_load, m_store;
  logic [31:0] d_rdata, m_addr, m_data_s;
  logic [3:0]  m_sel;

  urv_dm_arbiter #(.G_MAX_WAIT(8), .G_TIMEOUT(255)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .c_addr_i(c_addr), .c_data_s_i(c_data), .c_select_i(c_sel),
    .c_load_i(c_load), .c_store_i(c_store), .c_ready_o(c_ready),
    .d_addr_i(d_addr), .d_data_s_i(d_data), .d_select_i(d_sel),
    .d_load_i(d_load), .d_store_i(d_store), .d_ready_o(d_ready),
    .d_rdata_o(d_rdata), .d_err_o(d_err), .c_err_o(c_err),
    .m_addr_o(m_addr), .m_data_s_o(m_data_s), .m_select_o(m_sel),
    .m_load_o(m_load), .m_store_o(m_store),
    .m_data_l_i(m_data_l), .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    bit          store;
  } bus_exp_t;

  typedef struct {
    int unsigned cyc;
    logic [31:0] rdata;
  } rsp_exp_t;

  bus_exp_t    bus_q[$];
  int unsigned cr_q[$];
  rsp_exp_t    dr_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  logic        c_ready_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: who owns the bus, what it presented, and what each requester should see.
  initial begin : model
    int       owner;
    int       wt;
    logic [31:0] rdata_m;
    bus_exp_t lat, t;
    bit       creq, dreq, dwin, cwin;
    owner = 0; wt = 0; rdata_m = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        owner = 0; wt = 0; rdata_m = '0;
      end else begin
        creq = c_load | c_store;
        dreq = d_load | d_store;
        if (owner == 0) begin
          dwin = dreq && (wt == MAXW || !creq);
          cwin = creq && !dwin;
          if (dwin) t = '{cyc, d_addr, d_data, d_sel, d_store};
          else      t = '{cyc, c_addr, c_data, c_sel, c_store};
          if (dwin || cwin) begin
            bus_q.push_back(t);
            if (m_ready) begin
              if (cwin) cr_q.push_back(cyc);
              else begin
                if (!t.store) rdata_m = m_data_l;
                dr_q.push_back('{cyc + 1, rdata_m});
              end
            end else begin
              owner = dwin ? 2 : 1;
              lat = t;
            end
          end
          wt = (!dreq || dwin) ? 0 : ((wt < MAXW) ? wt + 1 : MAXW);
        end else begin
          t = lat;
          t.cyc = cyc;
          bus_q.push_back(t);
          if (!dreq) wt = 0;
          else if (owner == 1 && wt < MAXW) wt = wt + 1;
          if (m_ready) begin
            if (owner == 1) cr_q.push_back(cyc);
            else begin
              if (!lat.store) rdata_m = m_data_l;
              dr_q.push_back('{cyc + 1, rdata_m});
            end
            owner = 0;
          end
        end
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a strobe or a ready.
  initial begin : monitor
    bus_exp_t be;
    rsp_exp_t re;
    int unsigned ce;
    forever begin
      @(negedge clk);
      c_ready_seen = c_ready;
      if (!rst_n) begin
        bus_q.delete(); cr_q.delete(); dr_q.delete();
      end else begin
        if (m_load || m_store) begin
          if (bus_q.size() == 0) check("bus_unexpected", 32'(m_load | m_store), 32'd0);
          else begin
            be = bus_q.pop_front();
            check("bus_cyc", cyc, be.cyc);
            check("bus_addr", m_addr, be.addr);
            check("bus_data", m_data_s, be.data);
            check("bus_sel", 32'(m_sel), 32'(be.sel));
            check("bus_store", 32'(m_store), 32'(be.store));
            check("bus_load", 32'(m_load), 32'(!be.store));
          end
        end else if (bus_q.size() != 0 && bus_q[0].cyc == cyc) begin
          check("bus_missing", 32'd0, 32'd1);
          void'(bus_q.pop_front());
        end
        if (c_ready) begin
          if (cr_q.size() == 0) check("c_ready_unexpected", 32'(c_ready), 32'd0);
          else begin
            ce = cr_q.pop_front();
            check("c_ready_cyc", cyc, ce);
            check("c_err", 32'(c_err), 32'd0);
          end
        end
        if (d_ready) begin
          if (dr_q.size() == 0) check("d_ready_unexpected", 32'(d_ready), 32'd0);
          else begin
            re = dr_q.pop_front();
            check("d_ready_cyc", cyc, re.cyc);
            check("d_rdata", d_rdata, re.rdata);
            check("d_err", 32'(d_err), 32'd0);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    c_load = 1'b0; c_store = 1'b0; d_load = 1'b0; d_store = 1'b0;
  endtask

  initial begin : stim
    int unsigned s;
    bit got, c_act, d_act;
    int nstb, rdy_i, ckind, dkind;
    // Reset: a core request with a ready bus must not leak through.
    c_load = 1'b1; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_load", 32'(m_load), 32'd0);
    check("rst_m_store", 32'(m_store), 32'd0);
    check("rst_c_ready", 32'(c_ready), 32'd0);
    check("rst_d_ready", 32'(d_ready), 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_c_err", 32'(c_err), 32'd0);
    check("rst_d_err", 32'(d_err), 32'd0);
    @(posedge clk); #1;
    idle_inputs(); m_ready = 1'b0; rst_n = 1'b1;

    // Zero-wait core load.
    @(posedge clk); #1;
    c_load = 1'b1; c_addr = 32'h100; c_sel = 4'hF; m_ready = 1'b1;
    @(negedge clk);
    check("tp1_m_load", 32'(m_load), 32'd1);
    check("tp1_c_ready", 32'(c_ready), 32'd1);
    check("tp1_d_ready", 32'(d_ready), 32'd0);

    // Stalled core store, request withdrawn after the first cycle.
    nstb = 0; rdy_i = -1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      c_load = 1'b0; c_store = (i == 0);
      c_addr = (i == 0) ? 32'h204 : 32'h0;
      c_data = (i == 0) ? 32'hDEADBEEF : 32'h0;
      m_ready = (i == 3);
      @(negedge clk);
      if (m_store) nstb++;
      if (c_ready) rdy_i = i;
    end
    check("tp2_strobe_cycles", 32'(nstb), 32'd4);
    check("tp2_ready_cycle", 32'(rdy_i), 32'd3);

    // Debug load with core idle.
    @(posedge clk); #1;
    d_load = 1'b1; d_addr = 32'h40; d_sel = 4'hF; m_ready = 1'b1; m_data_l = 32'h12345678;
    @(negedge clk);
    check("tp3_d_ready_early", 32'(d_ready), 32'd0);
    @(posedge clk); #1;
    check("tp3_d_ready", 32'(d_ready), 32'd1);
    check("tp3_d_rdata", d_rdata, 32'h12345678);
    d_load = 1'b0; m_data_l = 32'hA5A5_0000;

    // Starvation guard: continuous core traffic on a zero-wait bus.
    @(posedge clk); #1;
    c_load = 1'b1; c_addr = 32'h1000; d_load = 1'b1; d_addr = 32'h80; m_ready = 1'b1;
    s = cyc; got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (cyc == s + 8) begin
        check("tp4_c_ready_at_grant", 32'(c_ready), 32'd0);
        check("tp4_grant_addr", m_addr, 32'h80);
      end
      @(posedge clk); #1;
      c_addr = c_addr + 32'd4;
      if (d_ready) begin
        got = 1'b1; d_load = 1'b0;
        check("tp4_latency", cyc - s, 32'd9);
      end
    end
    if (!got) check("tp4_timeout", 32'd0, 32'd1);
    idle_inputs();

    // Async reset in the middle of a stalled debug transaction.
    @(posedge clk); #1;
    d_load = 1'b1; d_addr = 32'h44; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    c_load = 1'b1; m_ready = 1'b1; rst_n = 1'b0;
    #1;
    check("tp5_m_load", 32'(m_load), 32'd0);
    check("tp5_m_store", 32'(m_store), 32'd0);
    check("tp5_c_ready", 32'(c_ready), 32'd0);
    check("tp5_d_ready", 32'(d_ready), 32'd0);
    @(posedge clk); #1;
    idle_inputs(); m_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("tp5_d_rdata", d_rdata, 32'd0);
    check("tp5_idle_load", 32'(m_load), 32'd0);

    // Random traffic against the model.
    c_act = 1'b0; d_act = 1'b0; ckind = 0; dkind = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (c_act && c_ready_seen) c_act = 1'b0;
      else if (c_act && $urandom_range(0, 15) == 0) c_act = 1'b0;
      else if (!c_act && $urandom_range(0, 2) == 0) begin
        c_act = 1'b1; c_addr = $urandom; c_data = $urandom; c_sel = 4'($urandom);
        ckind = int'($urandom_range(0, 2));
      end
      c_load  = c_act && (ckind != 1);
      c_store = c_act && (ckind != 0);
      if (d_act && d_ready) d_act = 1'b0;
      else if (!d_act && !d_ready && $urandom_range(0, 5) == 0) begin
        d_act = 1'b1; d_addr = $urandom; d_data = $urandom; d_sel = 4'($urandom);
        dkind = int'($urandom_range(0, 2));
      end
      d_load  = d_act && (dkind != 1);
      d_store = d_act && (dkind != 0);
      m_ready = 1'($urandom_range(0, 1));
      m_data_l = $urandom;
    end

    @(posedge clk); #1;
    idle_inputs(); m_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_bus_q", 32'(bus_q.size()), 32'd0);
    check("drain_cr_q", 32'(cr_q.size()), 32'd0);
    check("drain_dr_q", 32'(dr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
